// File: rtl/addr_serial_pkg.sv
// addr_serial_capture shared types, defaults and board bit permutation.
// The permutation is used only when ADDR_UNSCRAMBLE_EN is defined.
package addr_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int BITS_DEF        = 8;
    localparam int CLK_DIV_DEF     = 1;
    localparam int LOAD_CYCLES_DEF = 2;

    // Board wiring scrambles the address lines; undo it on the raw word.
    function automatic logic [15:0] addr_unscramble(input logic [15:0] r);
        return {r[11], r[12], r[14], r[2], r[6], r[7], r[13], r[9],
                r[8],  r[15], r[0],  r[1], r[5], r[3], r[4], 1'b0};
    endfunction

endpackage

// File: rtl/addr_serial_capture_lane.sv
// Serial-in shift register for one address lane, MSB-first.
// First sampled bit ends in the MSB after BITS samples.
module serial_lane
    import addr_serial_pkg::*;
#(
    parameter int BITS = BITS_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic            i_sdi,
    output logic [BITS-1:0] o_q
);

    logic [BITS-1:0] r_q;

    // Clear on capture start, shift one bit in per sample strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= {r_q[BITS-2:0], i_sdi};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/addr_serial_capture.sv
// Captures a 2*BITS address from two external PISO shift registers.
// Optional macro ADDR_UNSCRAMBLE_EN applies the board permutation to addr.
module addr_serial_capture
    import addr_serial_pkg::*;
#(
    parameter int BITS        = BITS_DEF,
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int LOAD_CYCLES = LOAD_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              adrin1,
    input  logic              adrin2,
    output logic              shld,
    output logic              serclk,
    output logic [4:0]        count,
    output logic              done,
    output logic [2*BITS-1:0] addr
);

    localparam logic [15:0] LD_LAST  = 16'(LOAD_CYCLES - 1);
    localparam logic [15:0] DV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [4:0]  CNT_LAST = 5'(BITS - 1);

    state_t          r_state;
    logic [15:0]     r_tmr;
    logic [4:0]      r_count;
    logic            r_shld;
    logic            r_serclk;
    logic            r_done;

    state_t          w_state_nx;
    logic [15:0]     w_tmr_nx;
    logic [4:0]      w_cnt_nx;
    logic            w_smp;
    logic            w_clr;
    logic [BITS-1:0] w_hi;
    logic [BITS-1:0] w_lo;
    logic [2*BITS-1:0] w_raw;

    // Next state, phase timer, bit count and lane strobes.
    always_comb begin
        w_state_nx = r_state;
        w_tmr_nx   = r_tmr;
        w_cnt_nx   = r_count;
        w_smp      = 1'b0;
        w_clr      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_tmr_nx = '0;
                if (run) begin
                    w_state_nx = LOAD;
                    w_clr      = 1'b1;
                end
            end
            LOAD: begin
                if (!run) begin
                    w_state_nx = IDLE;
                end else if (r_tmr == LD_LAST) begin
                    w_state_nx = LOW;
                    w_tmr_nx   = '0;
                end else begin
                    w_tmr_nx = r_tmr + 16'd1;
                end
            end
            LOW: begin
                if (!run) begin
                    w_state_nx = IDLE;
                end else if (r_tmr == DV_LAST) begin
                    w_smp      = 1'b1;
                    w_tmr_nx   = '0;
                    w_cnt_nx   = r_count + 5'd1;
                    w_state_nx = (r_count == CNT_LAST) ? DONE : HIGH;
                end else begin
                    w_tmr_nx = r_tmr + 16'd1;
                end
            end
            HIGH: begin
                if (!run) begin
                    w_state_nx = IDLE;
                end else if (r_tmr == DV_LAST) begin
                    w_state_nx = LOW;
                    w_tmr_nx   = '0;
                end else begin
                    w_tmr_nx = r_tmr + 16'd1;
                end
            end
            DONE: begin
                if (!run) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
        if (w_state_nx == IDLE) begin
            w_cnt_nx = '0;
            w_tmr_nx = '0;
        end
    end

    // State register with registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_tmr    <= '0;
            r_count  <= '0;
            r_shld   <= 1'b1;
            r_serclk <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_tmr    <= w_tmr_nx;
            r_count  <= w_cnt_nx;
            r_shld   <= (w_state_nx != LOAD);
            r_serclk <= (w_state_nx == HIGH);
            r_done   <= (w_state_nx == DONE);
        end
    end

    serial_lane #(.BITS(BITS)) u_lane1 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .i_en    (w_smp),
        .i_sdi   (adrin1),
        .o_q     (w_hi)
    );

    serial_lane #(.BITS(BITS)) u_lane2 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .i_en    (w_smp),
        .i_sdi   (adrin2),
        .o_q     (w_lo)
    );

    assign w_raw  = {w_hi, w_lo};
    assign shld   = r_shld;
    assign serclk = r_serclk;
    assign count  = r_count;
    assign done   = r_done;

`ifdef ADDR_UNSCRAMBLE_EN
    assign addr = addr_unscramble(w_raw);
`else
    assign addr = w_raw;
`endif

endmodule

// File: tb/tb_addr_serial_capture.sv
// Self-checking bench for addr_serial_capture with 74HC165 lane models.
// A phase-arithmetic reference model is compared every clock.
module tb_addr_serial_capture;

    localparam int B = 8;
    localparam int D = 1;
    localparam int L = 2;
    localparam int SHIFT_LEN = (2 * B - 1) * D;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        shld;
    logic        serclk;
    logic [4:0]  count;
    logic        done;
    logic [15:0] addr;

    logic [7:0]  pre1 = '0;
    logic [7:0]  pre2 = '0;
    logic [7:0]  sr1 = '0;
    logic [7:0]  sr2 = '0;
    wire         adrin1 = sr1[7];
    wire         adrin2 = sr2[7];

    int n_chk = 0;
    int n_pass = 0;
    int pulses = 0;

    bit          m_busy = 1'b0;
    int          m_j = 0;
    logic [15:0] m_raw = '0;

    addr_serial_capture #(
        .BITS        (B),
        .CLK_DIV     (D),
        .LOAD_CYCLES (L)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .adrin1  (adrin1),
        .adrin2  (adrin2),
        .shld    (shld),
        .serclk  (serclk),
        .count   (count),
        .done    (done),
        .addr    (addr)
    );

    always #5 clk = ~clk;

    // External 74HC165 pair: parallel load while shld low, shift on serclk rise.
    always @(posedge serclk or negedge shld) begin
        if (!shld) begin
            sr1 <= pre1;
            sr2 <= pre2;
        end else begin
            sr1 <= {sr1[6:0], 1'b0};
            sr2 <= {sr2[6:0], 1'b0};
        end
    end

    always @(posedge serclk) pulses++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %h exp %h", nm, act, exp);
    endtask

    function automatic logic [15:0] pm(input logic [15:0] r);
        int src [16] = '{11, 12, 14, 2, 6, 7, 13, 9, 8, 15, 0, 1, 5, 3, 4, -1};
        logic [15:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            if (src[i] >= 0) o[15-i] = r[src[i]];
        return o;
    endfunction

    function automatic logic [15:0] exp_out(input logic [15:0] raw);
`ifdef ADDR_UNSCRAMBLE_EN
        return pm(raw);
`else
        return raw;
`endif
    endfunction

    function automatic int exp_count();
        int q;
        if (!m_busy || m_j < L) return 0;
        q = m_j - L;
        if (q >= SHIFT_LEN) return B;
        return (q / D + 1) / 2;
    endfunction

    function automatic bit exp_done();
        return m_busy && m_j >= L && (m_j - L) >= SHIFT_LEN;
    endfunction

    function automatic bit exp_serclk();
        return m_busy && m_j >= L && (m_j - L) < SHIFT_LEN &&
               (((m_j - L) / D) % 2 == 1);
    endfunction

    function automatic bit exp_shld();
        return !(m_busy && m_j < L);
    endfunction

    function automatic logic [15:0] partial(input int c);
        logic [7:0] h;
        logic [7:0] l;
        if (c == 0) return '0;
        h = pre1 >> (B - c);
        l = pre2 >> (B - c);
        return {h, l};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_j = 0;
            m_raw = '0;
        end else if (!m_busy) begin
            if (run) begin
                m_busy = 1'b1;
                m_j = 0;
                m_raw = '0;
            end
        end else if (!run) begin
            m_busy = 1'b0;
        end else begin
            m_j++;
        end
        if (m_busy) m_raw = partial(exp_count());
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("shld", shld, exp_shld());
            chk("serclk", serclk, exp_serclk());
            chk("count", count, exp_count());
            chk("done", done, exp_done());
            chk("addr", addr, exp_out(m_raw));
        end
    end

    task automatic start(input logic [7:0] a, input logic [7:0] b);
        pre1 = a;
        pre2 = b;
        run = 1'b1;
    endtask

    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = i;
                break;
            end
        end
        if (edges < 0) begin
            n_chk++;
            $display("FAIL done_timeout got 0 exp 1");
        end
    endtask

    task automatic idle1();
        run = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int e;
        int k;
        chk("pm8000", pm(16'h8000), 16'h0040);
        chk("pm0001", pm(16'h0001), 16'h0020);
        chk("pm0800", pm(16'h0800), 16'h8000);

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_shld", shld, 1);
        chk("rst_count", count, 0);
        chk("rst_addr", addr, 0);

        pulses = 0;
        start(8'hA5, 8'h3C);
        wait_done(e);
        chk("latency", e, 17);
        chk("pulses", pulses, 7);
        chk("basic_addr", addr, exp_out(16'hA53C));
        chk("basic_count", count, 8);
        idle1();
        chk("idle_done", done, 0);
        chk("idle_count", count, 0);

        start(8'h5A, 8'hC3);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (count == 5'd4) break;
        end
        run = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_done", done, 0);
        chk("abort_count", count, 0);
        chk("abort_serclk", serclk, 0);
        chk("abort_addr", addr, exp_out(16'h050C));

        start(8'hFF, 8'h00);
        wait_done(e);
        chk("rerun_addr", addr, exp_out(16'hFF00));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_done", done, 1);
            chk("hold_addr", addr, exp_out(16'hFF00));
        end
        idle1();
        start(8'h12, 8'h34);
        wait_done(e);
        chk("restart_addr", addr, exp_out(16'h1234));
        idle1();

`ifdef ADDR_UNSCRAMBLE_EN
        start(8'h80, 8'h00);
        wait_done(e);
        chk("unscr_8000", addr, 16'h0040);
        idle1();
        start(8'h00, 8'h01);
        wait_done(e);
        chk("unscr_0001", addr, 16'h0020);
        idle1();
        start(8'h08, 8'h00);
        wait_done(e);
        chk("unscr_0800", addr, 16'h8000);
        idle1();
`endif

        start(8'h77, 8'h88);
        repeat (6) @(posedge clk);
        #2;
        reset_n = 1'b0;
        run = 1'b0;
        #1;
        chk("arst_shld", shld, 1);
        chk("arst_serclk", serclk, 0);
        chk("arst_count", count, 0);
        chk("arst_done", done, 0);
        chk("arst_addr", addr, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(3, 0);
            repeat (k) begin
                @(posedge clk);
                #1;
            end
            start(8'($urandom), 8'($urandom));
            k = $urandom_range(30, 1);
            repeat (k) begin
                @(posedge clk);
                #1;
            end
            idle1();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/addr_serial_capture.md
Name: addr_serial_capture

Overview:
- Captures the 16-bit host CPU address from two external 8-bit parallel-in/serial-out shift registers (74HC165-style).
- Generates the shift/load strobe (shld) and the serial clock (serclk), and samples two serial lanes MSB-first.
- Presents the assembled word with a done flag.
- Sits under the memory interface, which raises run at the start of a memory cycle and consumes addr when done=1.

Parameters:
- BITS, 8, bits per lane; the address is 2*BITS wide.
- CLK_DIV, 1, clk cycles per serclk half-period (>=1).
- LOAD_CYCLES, 2, clk cycles that shld is held low to parallel-load the external registers (>=1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level request: 1 = perform or hold a capture, 0 = abort/idle.
- adrin1  in  1  serial data, lane 1 (address high byte).
- adrin2  in  1  serial data, lane 2 (address low byte).
- shld  out  1  external shift/load; 0 = parallel load, 1 = shift.
- serclk  out  1  external shift clock; the external register shifts on its rising edge.
- count  out  5  bits sampled so far, 0..BITS.
- done  out  1  capture complete; addr valid.
- addr  out  2*BITS  captured word, {lane1, lane2}.

Behaviour:
- All outputs are registered.
- Reset (reset_n=0, asynchronous): state IDLE, shld=1, serclk=0, count=0, done=0, addr=0.
- States: IDLE, LOAD, LOW, HIGH, DONE.
- IDLE:
  - shld=1, serclk=0, done=0, count=0.
  - run=1 at an edge -> LOAD; addr is cleared to 0 on that edge.
- LOAD:
  - shld=0 for exactly LOAD_CYCLES cycles, then -> LOW with shld=1.
- LOW:
  - serclk=0 for CLK_DIV cycles.
  - On the last edge: addr[2*BITS-1:BITS] <= {addr[2*BITS-2:BITS], adrin1}; addr[BITS-1:0] <= {addr[BITS-2:0], adrin2}; count++.
  - If count reaches BITS -> DONE, else -> HIGH.
- HIGH:
  - serclk=1 for CLK_DIV cycles, then -> LOW.
- Pulse totals: 8 LOW phases and 7 serclk pulses; no trailing pulse.
- DONE:
  - done=1, count=BITS, addr held, serclk=0, shld=1.
  - Remains in DONE while run=1; run=0 -> IDLE (done drops next edge).
- Latency: if edge E0 sees run=1 in IDLE, done is 1 after edge E0 + LOAD_CYCLES + (2*BITS-1)*CLK_DIV, which is edge 17 with defaults.
- Abort: run=0 in any non-IDLE state -> IDLE on the next edge with the IDLE output values. addr keeps its partial value; it is valid only while done=1.
- Re-run while in DONE is not possible. run must drop for at least one cycle to start a new capture.
- Bit order: the first sampled bit ends in the MSB of its lane.

Optional Feature:
- Macro ADDR_UNSCRAMBLE_EN.
- Defined: addr is the board bit-permutation of the raw shift word r (bit 15 down to 0) = {r11, r12, r14, r2, r6, r7, r13, r9, r8, r15, r0, r1, r5, r3, r4, 1'b0}.
  - Applied combinationally on the registered raw word, so timing and done are unchanged.
  - Valid only for BITS=8.
- Undefined: addr = raw word.

Decomposition:
- Package addr_serial_pkg:
  - state enum (IDLE, LOAD, LOW, HIGH, DONE);
  - default constants BITS_DEF=8, CLK_DIV_DEF=1, LOAD_CYCLES_DEF=2;
  - the permutation as a function.
- Sub-module serial_lane:
  - BITS-wide serial-in shift register with a sample-enable and a clear;
  - instantiated once per lane.
- Controller FSM in the top module.

Test Plan:
- Reset then idle: reset_n=0 mid-capture -> shld=1, serclk=0, count=0, done=0, addr=0 immediately.
- Basic capture: bench 74HC165 models preloaded 0xA5 (lane1), 0x3C (lane2), run=1 held -> shld low 2 cycles, 7 serclk pulses, done at edge 17, addr=0xA53C, count=8.
- Count progress: same stimulus -> count increments 1..8, once per LOW phase; serclk never high while shld=0.
- Abort: run dropped after the 4th sample -> next edge IDLE, done=0, count=0. Re-run with 0xFF/0x00 -> addr=0xFF00.
- Hold and restart: run kept high 10 cycles after done -> done stays 1, addr stable. run low 1 cycle then high with 0x12/0x34 -> addr=0x1234.
- ADDR_UNSCRAMBLE_EN: raw 0x8000 -> addr=0x0040; raw 0x0001 -> addr=0x0020; raw 0x0800 -> addr=0x8000.
